current_source_array_dwa: RTL



---
 rtl/current_source_pkg.sv | 39 +++
 rtl/current_source_array_dwa_dwa_pointer.sv | 55 +++++
 rtl/current_source_array_dwa.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/current_source_pkg.sv
// Shared state type, supply/iref limits and helper functions for the segmented
// current-source array model.
`timescale 1ns/1ps
// Local definition of the undriven-real marker, used when cds_rnm_pkg is absent.
`ifndef wrealZState
`define wrealZState 1.0e99
`endif
package current_source_pkg;
    typedef enum logic [1:0] {OFF, SETTLE, ACTIVE, FAULT} cs_state_t;

    localparam real REAL_Z    = `wrealZState;
    localparam real IREF_NOM  = 500.0e-6;
    localparam real IREF_TOL  = 0.10;
    localparam real VDD18_NOM = 1.8;
    localparam real VDD08_NOM = 0.8;
    localparam real VDD_TOL   = 0.05;
    localparam real VSS_MAX   = 0.05;

    function automatic logic in_ok_check(input real iref, input real v18,
                                         input real v08, input real vss);
        logic ok_iref, ok_18, ok_08, ok_ss;
        ok_iref = (iref >= IREF_NOM * (1.0 - IREF_TOL)) && (iref <= IREF_NOM * (1.0 + IREF_TOL));
        ok_18   = (v18 >= VDD18_NOM * (1.0 - VDD_TOL)) && (v18 <= VDD18_NOM * (1.0 + VDD_TOL));
        ok_08   = (v08 >= VDD08_NOM * (1.0 - VDD_TOL)) && (v08 <= VDD08_NOM * (1.0 + VDD_TOL));
        ok_ss   = (vss >= -VSS_MAX) && (vss <= VSS_MAX);
        return ok_iref && ok_18 && ok_08 && ok_ss;
    endfunction

    // Deterministic per-unit draw: hash of (seed, index) mapped onto +/-pct percent.
    function automatic real mismatch_draw(input int unsigned seed, input int unsigned idx,
                                          input real pct);
        logic [31:0] x;
        x = seed ^ (idx * 32'h9E37_79B9);
        for (int r = 0; r < 4; r++) begin
            x = x * 32'd1664525 + 32'd1013904223;
        end
        return (2.0 * (real'(x[31:8]) / 16777216.0) - 1.0) * pct / 100.0;
    endfunction
endpackage

// File: rtl/current_source_array_dwa_dwa_pointer.sv
// Data-weighted-averaging pointer: registers the thermometer enable mask for a
// captured unit count and advances the rotation pointer.
`timescale 1ns/1ps
module dwa_pointer
    import current_source_pkg::*;
#(
    parameter int  N_THERM = 17,
    localparam int KW = $clog2(N_THERM + 1),
    localparam int PW = (N_THERM > 1) ? $clog2(N_THERM) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [KW-1:0]      k,
    input  logic               dem_ena,
    output logic [N_THERM-1:0] mask,
    output logic [PW-1:0]      ptr
);
    logic [N_THERM-1:0] mask_q, mask_d, hit;
    logic [PW-1:0]      ptr_q, ptr_d;
    int                 sum;

    // Unit gi is on when its distance ahead of the pointer (mod N_THERM) is below k.
    for (genvar gi = 0; gi < N_THERM; gi++) begin : g_unit
        int off_i;
        assign off_i   = (gi >= int'(ptr_q)) ? gi - int'(ptr_q) : gi + N_THERM - int'(ptr_q);
        assign hit[gi] = dem_ena ? (off_i < int'(k)) : (gi < int'(k));
    end

    always_comb begin
        mask_d = mask_q;
        ptr_d  = ptr_q;
        sum    = 0;
        if (load) begin
            mask_d = hit;
            if (dem_ena) begin
                sum   = int'(ptr_q) + int'(k);
                ptr_d = PW'((sum >= N_THERM) ? sum - N_THERM : sum);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q <= '0;
            ptr_q  <= '0;
        end else begin
            mask_q <= mask_d;
            ptr_q  <= ptr_d;
        end
    end

    assign mask = mask_q;
    assign ptr  = ptr_q;
endmodule

// File: rtl/current_source_array_dwa.sv
// Segmented thermometer/binary current-source array (real-number model) with
// power-up/fault sequencing, registered code capture and DWA unit rotation.
`timescale 1ns/1ps
module current_source_array_dwa
    import current_source_pkg::*;
#(
    parameter int  N_THERM        = 17,
    parameter int  N_BIN          = 6,
    parameter real UNIT_DIV       = 2.5,
    parameter int  SETTLE_CYCLES  = 16,
    parameter int  FAULT_DEBOUNCE = 4,
    parameter bit  MISMATCH_EN    = 1'b1,
    parameter real MISMATCH_PCT   = 2.0,
    parameter int  SEED           = 1,
    localparam int KW = $clog2(N_THERM + 1),
    localparam int PW = (N_THERM > 1) ? $clog2(N_THERM) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  real              iref,
    input  real              vddana_1p8,
    input  real              vddana_0p8,
    input  real              vssana,
    input  logic             pdb,
    input  logic             code_valid,
    input  logic [KW-1:0]    therm_cnt,
    input  logic [N_BIN-1:0] bin_code,
    input  logic             dem_ena,
    input  logic             red_sel,
    input  logic [1:0]       atb_ena,
    output real              iout_therm [N_THERM],
    output real              iout_bin [N_BIN],
    output real              iout_bin_red,
    output real              iout_total,
    output real              atb1,
    output real              atb0,
    output logic             ready,
    output logic             fault,
    output logic             ovf,
    output logic [PW-1:0]    dwa_ptr
);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int FW = $clog2(FAULT_DEBOUNCE + 1);

    cs_state_t          state_q, state_d;
    logic [SW-1:0]      settle_cnt_q, settle_cnt_d;
    logic [FW-1:0]      bad_cnt_q, bad_cnt_d;
    logic [N_BIN-1:0]   bin_q, bin_d;
    logic               ovf_q, ovf_d;
    logic               in_ok, load, is_off, is_act;
    logic [KW-1:0]      k_sat;
    logic [N_THERM-1:0] en_mask;
    real                m_therm [N_THERM];
    real                m_bin [N_BIN];
    real                m_red;
    real                therm_val [N_THERM];
    real                bin_val [N_BIN];
    real                red_val, unit_i, total_sum;

    always_comb in_ok = in_ok_check(iref, vddana_1p8, vddana_0p8, vssana);

    assign k_sat = (int'(therm_cnt) > N_THERM) ? KW'(N_THERM) : therm_cnt;

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        bad_cnt_d    = bad_cnt_q;
        if (!pdb) begin
            state_d      = OFF;
            settle_cnt_d = '0;
            bad_cnt_d    = '0;
        end else begin
            case (state_q)
                OFF: if (in_ok) begin
                    state_d      = SETTLE;
                    settle_cnt_d = '0;
                end
                SETTLE: begin
                    if (!in_ok) begin
                        state_d = OFF;
                    end else if (int'(settle_cnt_q) == SETTLE_CYCLES - 1) begin
                        state_d   = ACTIVE;
                        bad_cnt_d = '0;
                    end else begin
                        settle_cnt_d = settle_cnt_q + 1'b1;
                    end
                end
                ACTIVE: begin
                    if (in_ok) begin
                        bad_cnt_d = '0;
                    end else if (int'(bad_cnt_q) == FAULT_DEBOUNCE - 1) begin
                        state_d = FAULT;
                    end else begin
                        bad_cnt_d = bad_cnt_q + 1'b1;
                    end
                end
                default: state_d = FAULT;
            endcase
        end
        // A capture on the edge that leaves ACTIVE must not land.
        load  = code_valid && (state_q == ACTIVE) && (state_d == ACTIVE);
        bin_d = load ? bin_code : bin_q;
        ovf_d = ovf_q;
        if (!pdb) begin
            ovf_d = 1'b0;
        end else if (load && (int'(therm_cnt) > N_THERM)) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= OFF;
            settle_cnt_q <= '0;
            bad_cnt_q    <= '0;
            bin_q        <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            bad_cnt_q    <= bad_cnt_d;
            bin_q        <= bin_d;
            ovf_q        <= ovf_d;
        end
    end

    dwa_pointer #(.N_THERM(N_THERM)) u_dwa (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .k       (k_sat),
        .dem_ena (dem_ena),
        .mask    (en_mask),
        .ptr     (dwa_ptr)
    );

    always_comb begin
        for (int i = 0; i < N_THERM; i++) begin
            m_therm[i] = MISMATCH_EN ? mismatch_draw(SEED, i, MISMATCH_PCT) : 0.0;
        end
        for (int b = 0; b < N_BIN; b++) begin
            m_bin[b] = MISMATCH_EN ? mismatch_draw(SEED, N_THERM + b, MISMATCH_PCT) : 0.0;
        end
        m_red = MISMATCH_EN ? mismatch_draw(SEED, N_THERM + N_BIN, MISMATCH_PCT) : 0.0;
    end

    assign is_off = (state_q == OFF);
    assign is_act = (state_q == ACTIVE);

    always_comb begin
        unit_i    = iref / UNIT_DIV;
        total_sum = 0.0;
        for (int i = 0; i < N_THERM; i++) begin
            therm_val[i] = en_mask[i] ? unit_i * (1.0 + m_therm[i]) : 0.0;
            total_sum   += therm_val[i];
        end
        for (int b = 0; b < N_BIN; b++) begin
            bin_val[b] = bin_q[b] ? unit_i / real'(1 << (N_BIN - b)) * (1.0 + m_bin[b]) : 0.0;
        end
        // The redundant LSB unit takes over bit 0 when selected.
        red_val = (red_sel && bin_q[0]) ? unit_i / real'(1 << N_BIN) * (1.0 + m_red) : 0.0;
        if (red_sel) begin
            bin_val[0] = 0.0;
        end
        for (int b = 0; b < N_BIN; b++) begin
            total_sum += bin_val[b];
        end
        total_sum += red_val;

        for (int i = 0; i < N_THERM; i++) begin
            iout_therm[i] = is_off ? REAL_Z : (is_act ? therm_val[i] : 0.0);
        end
        for (int b = 0; b < N_BIN; b++) begin
            iout_bin[b] = is_off ? REAL_Z : (is_act ? bin_val[b] : 0.0);
        end
        iout_bin_red = is_off ? REAL_Z : (is_act ? red_val : 0.0);
        iout_total   = is_off ? REAL_Z : (is_act ? total_sum : 0.0);
    end

    always_comb begin
        atb1 = REAL_Z;
        atb0 = REAL_Z;
        if (!is_off) begin
            case (atb_ena)
                2'b01: begin
                    atb1 = vddana_1p8;
                    atb0 = vssana;
                end
                2'b10: begin
                    atb1 = vddana_0p8;
                    atb0 = iout_therm[0];
                end
                2'b11: begin
                    atb1 = iref;
                    atb0 = iout_total;
                end
                default: ;
            endcase
        end
    end

    assign ready = is_act;
    assign fault = (state_q == FAULT);
    assign ovf   = ovf_q;
endmodule
